strobe_measure_ctrl: RTL
========================

Name: strobe_measure_ctrl

Overview:
Sequencer for a strobe-width measurement channel. On a start command it arms the engine, waits for the data strobe, counts the strobe's high cycles and presents the result through a valid/ready handshake. It aborts on timeout or on request. It sits between the host command interface and the strobe/engine datapath, and supplies the waiting/counting status consumed by the status logic.

Parameters:
CNT_W, 16, width of the measured high-cycle count
TIMEOUT, 255, max cycles spent in WAIT before a timeout abort (legal range 2..65535)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  measurement request, level-sampled each cycle
abort  in  1  cancel the in-progress measurement
d_s  in  1  data strobe, already synchronized to clk
result_ready  in  1  consumer accepts the result
eng_arm  out  1  one-cycle engine arm pulse
waiting  out  1  high while in WAIT
counting  out  1  high while in COUNT
result  out  CNT_W  measured high-cycle count
result_valid  out  1  result, timeout_err and overflow are valid
timeout_err  out  1  measurement ended by timeout
overflow  out  1  count saturated

Behaviour:
- Reset: n_rst is asynchronous and active-low; clock is clk. The FSM goes to IDLE and every output is 0 (result = 0).
- The FSM is fully registered. Outputs are decoded from state or registers only; no input-to-output combinational paths.
- IDLE: start=1 -> ARM. All other inputs are ignored.
- ARM (exactly 1 cycle):
  - eng_arm=1.
  - Count, timer, timeout_err and overflow are cleared.
  - Next state is WAIT, regardless of inputs (abort is ignored in ARM).
- WAIT:
  - waiting=1; the timer increments each cycle.
  - Priority order: abort, then d_s, then timeout.
  - abort=1 -> IDLE. No result is produced.
  - d_s=1 -> COUNT, count loaded with 1. The first high cycle is counted.
  - Timer == TIMEOUT-1 with d_s=0 -> DONE with timeout_err=1 and result=0. WAIT therefore lasts at most TIMEOUT cycles.
- COUNT:
  - counting=1.
  - abort=1 -> IDLE. No result is produced.
  - d_s=1: count increments, saturating at 2^CNT_W-1. An increment attempted at max sets overflow (sticky until the next ARM).
  - d_s=0 -> DONE. result = number of consecutive d_s-high cycles.
- DONE:
  - result_valid=1. result, timeout_err and overflow are held stable until the handshake completes.
  - result_ready=1 and start=1 -> ARM (back-to-back measurement).
  - result_ready=1 and start=0 -> IDLE.
  - result_ready=0: stay in DONE. start and abort are ignored in DONE.
- waiting, counting and result_valid are mutually exclusive, and at most one of them is high per cycle.
- In IDLE and ARM, result and its flags show 0 (cleared on ARM). After a completed handshake they keep their last value while in IDLE. They are meaningful only when result_valid=1.
- Latency:
  - start in IDLE -> eng_arm 1 cycle later -> waiting 2 cycles later.
  - For a strobe of N high cycles, result_valid asserts on the cycle after d_s falls.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A pending result is lost.

Test Plan:
- Reset during COUNT (n_rst low mid-strobe, async) -> all outputs 0 immediately. After release, the FSM stays in IDLE until start.
- Basic measurement: start=1 for 1 cycle, d_s high for 5 cycles, 3 cycles after eng_arm, result_ready=1.
  - Expect: eng_arm a single pulse; waiting for 3 cycles; counting for 5 cycles; result_valid with result=5, timeout_err=0, overflow=0; return to IDLE.
- Timeout: TIMEOUT=10, start, d_s held 0.
  - Expect: waiting for exactly 10 cycles, then result_valid with result=0 and timeout_err=1.
- Saturation: CNT_W=4, d_s high for 20 cycles.
  - Expect: result=15 and overflow=1.
  - Next measurement with a 3-cycle strobe: result=3, overflow=0.
- Back-pressure and back-to-back:
  - Hold result_ready=0 for 7 cycles in DONE while toggling d_s, start and abort -> outputs are stable.
  - Then result_ready=1 with start=1 -> eng_arm the next cycle and flags cleared.
- Abort: abort=1 in WAIT, then in a later run abort=1 on the 3rd COUNT cycle.
  - Expect: IDLE the next cycle each time, no result_valid, no eng_arm until a new start.

Source files
------------

// File: rtl/strobe_measure_ctrl.sv
// Strobe-width measurement sequencer: arms the engine, waits for the data strobe,
// counts its high cycles and offers the count through a valid/ready handshake.
module strobe_measure_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             d_s,
  input  logic             result_ready,
  output logic             eng_arm,
  output logic             waiting,
  output logic             counting,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             timeout_err,
  output logic             overflow,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0]      TMR_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             ovf_q, ovf_d;

  // Handshake: result_valid is high for the whole of DONE; the result, timeout_err
  // and overflow do not change while result_valid=1 and result_ready=0, and the
  // transfer completes on the first rising edge where both are high.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          timer_d = '0;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_ARM: begin
        state_d = S_WAIT;
        timer_d = '0;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (d_s) begin
          // The cycle that detects the strobe is its first high cycle.
          state_d = S_COUNT;
          cnt_d   = CNT_W'(1);
        end else if (timer_q == TMR_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (d_s) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          if (start) begin
            state_d = S_ARM;
            timer_d = '0;
            cnt_d   = '0;
            tmo_d   = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign eng_arm      = (state_q == S_ARM);
  assign waiting      = (state_q == S_WAIT);
  assign counting     = (state_q == S_COUNT);
  assign result_valid = (state_q == S_DONE);
  assign result       = cnt_q;
  assign timeout_err  = tmo_q;
  assign overflow     = ovf_q;
  assign dbg_state    = state_q;

endmodule
